// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath bundle: decode inputs from the IR/ALU/memory,
// mux selects and write strobes back to the multicycle datapath.
interface multicycle_control_unit_if;
   logic [31:0] Instr;
   logic        Zero;
   logic        Negative;
   logic        MemReady;
   logic        RegWrite;
   logic        MemWrite;
   logic        IRWrite;
   logic        PCWrite;
   logic        AdrSrc;
   logic [1:0]  ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [1:0]  ResultSrc;
   logic [2:0]  ImmSrc;
   logic [4:0]  ALUControl;
   logic        IllegalInstr;
   logic [3:0]  State;

   modport master (
      input  Instr, Zero, Negative, MemReady,
      output RegWrite, MemWrite, IRWrite, PCWrite, AdrSrc, ALUSrcA, ALUSrcB,
             ResultSrc, ImmSrc, ALUControl, IllegalInstr, State
   );

   modport slave (
      output Instr, Zero, Negative, MemReady,
      input  RegWrite, MemWrite, IRWrite, PCWrite, AdrSrc, ALUSrcA, ALUSrcB,
             ResultSrc, ImmSrc, ALUControl, IllegalInstr, State
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: sequences each instruction over 3-5 cycles,
// with optional memory-ready stalls and illegal-opcode trapping.
module multicycle_control_unit #(
   parameter bit MEM_HANDSHAKE = 1'b1,
   parameter bit TRAP_EN       = 1'b1
) (
   input logic                        clk,
   input logic                        reset,
   multicycle_control_unit_if.master  bus
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR1    = 4'd11,
      S_JALR2    = 4'd12,
      S_LUI      = 4'd13,
      S_TRAP     = 4'd14
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [4:0] ALU_ADD   = 5'b00000;
   localparam logic [4:0] ALU_SUB   = 5'b00001;
   localparam logic [4:0] ALU_AND   = 5'b00010;
   localparam logic [4:0] ALU_OR    = 5'b00011;
   localparam logic [4:0] ALU_XOR   = 5'b00100;
   localparam logic [4:0] ALU_SLT   = 5'b00101;
   localparam logic [4:0] ALU_SLTU  = 5'b00110;
   localparam logic [4:0] ALU_SLL   = 5'b00111;
   localparam logic [4:0] ALU_SRL   = 5'b01000;
   localparam logic [4:0] ALU_SRA   = 5'b01001;
   localparam logic [4:0] ALU_PASSB = 5'b01010;

   state_t     state;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       b30;
   logic       ready;
   logic       unused_instr;

   assign op           = bus.Instr[6:0];
   assign funct3       = bus.Instr[14:12];
   assign b30          = bus.Instr[30];
   assign unused_instr = ^{bus.Instr[31], bus.Instr[29:15], bus.Instr[11:7]};
   assign ready        = MEM_HANDSHAKE ? bus.MemReady : 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_FETCH;
      end else begin
         case (state)
            S_FETCH:    if (ready) state <= S_DECODE;
            S_DECODE: begin
               case (op)
                  OP_LOAD, OP_STORE: state <= S_MEMADR;
                  OP_RTYPE:          state <= S_EXECR;
                  OP_ITYPE:          state <= S_EXECI;
                  OP_BRANCH:         state <= S_BRANCH;
                  OP_JAL:            state <= S_JAL;
                  OP_JALR:           state <= S_JALR1;
                  OP_LUI:            state <= S_LUI;
                  default:           state <= TRAP_EN ? S_TRAP : S_FETCH;
               endcase
            end
            S_MEMADR:   state <= (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (ready) state <= S_MEMWB;
            S_MEMWRITE: if (ready) state <= S_FETCH;
            S_MEMWB, S_ALUWB, S_BRANCH: state <= S_FETCH;
            S_EXECR, S_EXECI, S_JAL, S_JALR2, S_LUI: state <= S_ALUWB;
            S_JALR1:    state <= S_JALR2;
            S_TRAP:     state <= S_TRAP;
            default:    state <= S_FETCH;
         endcase
      end
   end

   logic [4:0] exec_alu;
   logic       taken;
   logic       regwrite, memwrite, irwrite, pcwrite, illegal;

   always_comb begin
      case (funct3)
         3'b000:  exec_alu = (state == S_EXECR && b30) ? ALU_SUB : ALU_ADD;
         3'b001:  exec_alu = ALU_SLL;
         3'b010:  exec_alu = ALU_SLT;
         3'b011:  exec_alu = ALU_SLTU;
         3'b100:  exec_alu = ALU_XOR;
         3'b101:  exec_alu = b30 ? ALU_SRA : ALU_SRL;
         3'b110:  exec_alu = ALU_OR;
         default: exec_alu = ALU_AND;
      endcase
      // Unsigned compares go through SLTU, so its result is zero when a >= b
      case (funct3)
         3'b000:  taken = bus.Zero;
         3'b001:  taken = ~bus.Zero;
         3'b100:  taken = bus.Negative;
         3'b101:  taken = ~bus.Negative;
         3'b110:  taken = ~bus.Zero;
         3'b111:  taken = bus.Zero;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      regwrite       = 1'b0;
      memwrite       = 1'b0;
      irwrite        = 1'b0;
      pcwrite        = 1'b0;
      illegal        = 1'b0;
      bus.AdrSrc     = 1'b0;
      bus.ALUSrcA    = 2'b00;
      bus.ALUSrcB    = 2'b00;
      bus.ResultSrc  = 2'b00;
      bus.ImmSrc     = 3'b000;
      bus.ALUControl = ALU_ADD;
      case (state)
         S_FETCH: begin
            bus.ALUSrcB   = 2'b10;
            bus.ResultSrc = 2'b10;
            irwrite       = ready;
            pcwrite       = ready;
         end
         S_DECODE: begin
            bus.ALUSrcA = 2'b01;
            bus.ALUSrcB = 2'b01;
            bus.ImmSrc  = 3'b010;
         end
         S_MEMADR: begin
            bus.ALUSrcA = 2'b10;
            bus.ALUSrcB = 2'b01;
            bus.ImmSrc  = (op == OP_STORE) ? 3'b001 : 3'b000;
         end
         S_MEMREAD:  bus.AdrSrc = 1'b1;
         S_MEMWB: begin
            bus.ResultSrc = 2'b01;
            regwrite      = 1'b1;
         end
         S_MEMWRITE: begin
            bus.AdrSrc = 1'b1;
            memwrite   = 1'b1;
         end
         S_EXECR, S_EXECI: begin
            bus.ALUSrcA    = 2'b10;
            bus.ALUSrcB    = (state == S_EXECI) ? 2'b01 : 2'b00;
            bus.ALUControl = exec_alu;
         end
         S_ALUWB:    regwrite = 1'b1;
         S_BRANCH: begin
            bus.ALUSrcA    = 2'b10;
            bus.ALUControl = (funct3[2:1] == 2'b11) ? ALU_SLTU : ALU_SUB;
            pcwrite        = taken;
         end
         S_JAL: begin
            bus.ALUSrcA = 2'b01;
            bus.ALUSrcB = 2'b10;
            bus.ImmSrc  = 3'b011;
            pcwrite     = 1'b1;
         end
         S_JALR1: begin
            bus.ALUSrcA = 2'b10;
            bus.ALUSrcB = 2'b01;
         end
         S_JALR2: begin
            bus.ALUSrcA = 2'b01;
            bus.ALUSrcB = 2'b10;
            pcwrite     = 1'b1;
         end
         S_LUI: begin
            bus.ALUSrcB    = 2'b01;
            bus.ImmSrc     = 3'b100;
            bus.ALUControl = ALU_PASSB;
         end
         S_TRAP:     illegal = 1'b1;
         default: ;
      endcase
   end

   // Reset gates strobes combinationally so a stalled write drops at once
   assign bus.RegWrite     = regwrite & ~reset;
   assign bus.MemWrite     = memwrite & ~reset;
   assign bus.IRWrite      = irwrite  & ~reset;
   assign bus.PCWrite      = pcwrite  & ~reset;
   assign bus.IllegalInstr = illegal  & ~reset;
   assign bus.State        = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: one handshaking/trapping
// instance and one with MemReady ignored and illegal opcodes as no-ops.
module tb_multicycle_control_unit;

   localparam logic [31:0] I_ADD   = 32'h002081B3;
   localparam logic [31:0] I_SUB   = 32'h402081B3;
   localparam logic [31:0] I_SRAI  = 32'h4010D093;
   localparam logic [31:0] I_ADDI  = 32'h40000093;
   localparam logic [31:0] I_LW    = 32'h0000A183;
   localparam logic [31:0] I_SW    = 32'h0020A023;
   localparam logic [31:0] I_BEQ   = 32'h00000063;
   localparam logic [31:0] I_BNE   = 32'h00001063;
   localparam logic [31:0] I_BLT   = 32'h00004063;
   localparam logic [31:0] I_BGEU  = 32'h00007063;
   localparam logic [31:0] I_JAL   = 32'h0000006F;
   localparam logic [31:0] I_JALR  = 32'h00508167;
   localparam logic [31:0] I_LUI   = 32'h000011B7;
   localparam logic [31:0] I_ILL   = 32'h0000007F;

   logic        clk;
   logic        reset;
   logic        rstb;
   logic [31:0] instr;
   logic        zero;
   logic        neg;
   logic        memready;
   int          checks;
   int          errors;

   multicycle_control_unit_if ifa ();
   multicycle_control_unit_if ifb ();

   assign ifa.Instr    = instr;
   assign ifa.Zero     = zero;
   assign ifa.Negative = neg;
   assign ifa.MemReady = memready;
   assign ifb.Instr    = instr;
   assign ifb.Zero     = zero;
   assign ifb.Negative = neg;
   assign ifb.MemReady = memready;

   multicycle_control_unit #(.MEM_HANDSHAKE(1'b1), .TRAP_EN(1'b1)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa.master)
   );

   multicycle_control_unit #(.MEM_HANDSHAKE(1'b0), .TRAP_EN(1'b0)) dut_b (
      .clk   (clk),
      .reset (rstb),
      .bus   (ifb.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock, then apply MemReady and let outputs settle
   task automatic step(input logic mr);
      @(posedge clk);
      #1;
      memready = mr;
      #1;
   endtask

   task automatic go(input int n);
      for (int i = 0; i < n; i++) step(1'b1);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      rstb = 1'b1;
      memready = 1'b1;
      zero = 1'b0;
      neg = 1'b0;
      instr = 32'h0;

      #12;
      check("rst_state", 32'(ifa.State), 0);
      check("rst_irwrite", 32'(ifa.IRWrite), 0);
      check("rst_pcwrite", 32'(ifa.PCWrite), 0);
      check("rst_alusrcb", 32'(ifa.ALUSrcB), 2);
      check("rst_resultsrc", 32'(ifa.ResultSrc), 2);
      check("rst_illegal", 32'(ifa.IllegalInstr), 0);

      @(posedge clk);
      #1;
      reset = 1'b0;
      instr = I_ADD;
      #1;
      check("add_fetch_state", 32'(ifa.State), 0);
      check("add_fetch_irwrite", 32'(ifa.IRWrite), 1);
      go(1);
      check("add_dec_state", 32'(ifa.State), 1);
      check("add_dec_srca", 32'(ifa.ALUSrcA), 1);
      check("add_dec_imm", 32'(ifa.ImmSrc), 2);
      check("add_dec_regwrite", 32'(ifa.RegWrite), 0);
      go(1);
      check("add_exec_state", 32'(ifa.State), 6);
      check("add_exec_alu", 32'(ifa.ALUControl), 0);
      check("add_exec_regwrite", 32'(ifa.RegWrite), 0);
      go(1);
      check("add_wb_state", 32'(ifa.State), 8);
      check("add_wb_regwrite", 32'(ifa.RegWrite), 1);
      go(1);
      check("add_done_state", 32'(ifa.State), 0);

      instr = I_SUB;
      go(2);
      check("sub_alu", 32'(ifa.ALUControl), 1);
      go(2);
      instr = I_SRAI;
      go(2);
      check("srai_state", 32'(ifa.State), 7);
      check("srai_alu", 32'(ifa.ALUControl), 9);
      check("srai_srcb", 32'(ifa.ALUSrcB), 1);
      go(2);
      instr = I_ADDI;
      go(2);
      check("addi_b30_alu", 32'(ifa.ALUControl), 0);
      go(2);

      instr = I_LW;
      go(2);
      check("lw_adr_state", 32'(ifa.State), 2);
      check("lw_adr_imm", 32'(ifa.ImmSrc), 0);
      check("lw_adr_srca", 32'(ifa.ALUSrcA), 2);
      step(1'b0);
      check("lw_rd1_state", 32'(ifa.State), 3);
      check("lw_rd1_adrsrc", 32'(ifa.AdrSrc), 1);
      step(1'b0);
      check("lw_rd2_state", 32'(ifa.State), 3);
      check("lw_rd2_adrsrc", 32'(ifa.AdrSrc), 1);
      step(1'b1);
      check("lw_rd3_state", 32'(ifa.State), 3);
      check("lw_rd3_adrsrc", 32'(ifa.AdrSrc), 1);
      go(1);
      check("lw_wb_state", 32'(ifa.State), 4);
      check("lw_wb_resultsrc", 32'(ifa.ResultSrc), 1);
      check("lw_wb_regwrite", 32'(ifa.RegWrite), 1);
      go(1);
      check("lw_done_state", 32'(ifa.State), 0);

      instr = I_SW;
      memready = 1'b0;
      #1;
      check("sw_f1_irwrite", 32'(ifa.IRWrite), 0);
      step(1'b0);
      check("sw_f2_pcwrite", 32'(ifa.PCWrite), 0);
      step(1'b0);
      check("sw_f3_state", 32'(ifa.State), 0);
      check("sw_f3_irwrite", 32'(ifa.IRWrite), 0);
      step(1'b1);
      check("sw_f4_irwrite", 32'(ifa.IRWrite), 1);
      go(1);
      check("sw_dec_memwrite", 32'(ifa.MemWrite), 0);
      go(1);
      check("sw_adr_imm", 32'(ifa.ImmSrc), 1);
      check("sw_adr_memwrite", 32'(ifa.MemWrite), 0);
      go(1);
      check("sw_wr_state", 32'(ifa.State), 5);
      check("sw_wr_memwrite", 32'(ifa.MemWrite), 1);
      go(1);
      check("sw_done_state", 32'(ifa.State), 0);
      check("sw_done_memwrite", 32'(ifa.MemWrite), 0);

      zero = 1'b1;
      instr = I_BEQ;
      go(2);
      check("beq_state", 32'(ifa.State), 9);
      check("beq_pcwrite", 32'(ifa.PCWrite), 1);
      check("beq_alu", 32'(ifa.ALUControl), 1);
      go(1);
      instr = I_BNE;
      go(2);
      check("bne_pcwrite", 32'(ifa.PCWrite), 0);
      go(1);
      zero = 1'b0;
      neg = 1'b1;
      instr = I_BLT;
      go(2);
      check("blt_pcwrite", 32'(ifa.PCWrite), 1);
      go(1);
      zero = 1'b1;
      neg = 1'b0;
      instr = I_BGEU;
      go(2);
      check("bgeu_alu", 32'(ifa.ALUControl), 6);
      check("bgeu_pcwrite", 32'(ifa.PCWrite), 1);
      go(1);
      check("branch_done_state", 32'(ifa.State), 0);
      zero = 1'b0;

      instr = I_JAL;
      go(2);
      check("jal_state", 32'(ifa.State), 10);
      check("jal_pcwrite", 32'(ifa.PCWrite), 1);
      check("jal_imm", 32'(ifa.ImmSrc), 3);
      go(1);
      check("jal_wb_regwrite", 32'(ifa.RegWrite), 1);
      go(1);

      instr = I_JALR;
      go(2);
      check("jalr1_state", 32'(ifa.State), 11);
      check("jalr1_pcwrite", 32'(ifa.PCWrite), 0);
      go(1);
      check("jalr2_state", 32'(ifa.State), 12);
      check("jalr2_pcwrite", 32'(ifa.PCWrite), 1);
      check("jalr2_srca", 32'(ifa.ALUSrcA), 1);
      check("jalr2_srcb", 32'(ifa.ALUSrcB), 2);
      go(1);
      check("jalr_wb_state", 32'(ifa.State), 8);
      check("jalr_wb_pcwrite", 32'(ifa.PCWrite), 0);
      check("jalr_wb_regwrite", 32'(ifa.RegWrite), 1);
      go(1);

      instr = I_LUI;
      go(2);
      check("lui_state", 32'(ifa.State), 13);
      check("lui_alu", 32'(ifa.ALUControl), 10);
      check("lui_imm", 32'(ifa.ImmSrc), 4);
      go(2);

      instr = I_SW;
      go(3);
      memready = 1'b0;
      #1;
      check("swrst_state", 32'(ifa.State), 5);
      check("swrst_memwrite", 32'(ifa.MemWrite), 1);
      step(1'b0);
      check("swrst_hold", 32'(ifa.MemWrite), 1);
      #2;
      reset = 1'b1;
      #1;
      check("swrst_drop", 32'(ifa.MemWrite), 0);
      check("swrst_fetch", 32'(ifa.State), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      memready = 1'b1;
      #1;
      check("swrst_restart", 32'(ifa.State), 0);

      instr = I_ILL;
      go(2);
      check("trap_state", 32'(ifa.State), 14);
      check("trap_illegal", 32'(ifa.IllegalInstr), 1);
      go(3);
      check("trap_hold_state", 32'(ifa.State), 14);
      check("trap_hold_illegal", 32'(ifa.IllegalInstr), 1);
      check("trap_pcwrite", 32'(ifa.PCWrite), 0);
      reset = 1'b1;
      #1;
      check("trap_rst_state", 32'(ifa.State), 0);
      check("trap_rst_illegal", 32'(ifa.IllegalInstr), 0);

      rstb = 1'b0;
      memready = 1'b0;
      #1;
      check("nt_fetch_state", 32'(ifb.State), 0);
      check("nt_fetch_irwrite", 32'(ifb.IRWrite), 1);
      step(1'b0);
      check("nt_dec_state", 32'(ifb.State), 1);
      check("nt_dec_strobes", 32'({ifb.RegWrite, ifb.MemWrite, ifb.IRWrite, ifb.PCWrite}), 0);
      step(1'b0);
      check("nt_back_state", 32'(ifb.State), 0);
      check("nt_illegal", 32'(ifb.IllegalInstr), 0);
      instr = I_LW;
      step(1'b0);
      step(1'b0);
      step(1'b0);
      check("nh_rd_state", 32'(ifb.State), 3);
      check("nh_rd_adrsrc", 32'(ifb.AdrSrc), 1);
      step(1'b0);
      check("nh_wb_state", 32'(ifb.State), 4);
      step(1'b0);
      instr = I_SW;
      step(1'b0);
      step(1'b0);
      step(1'b0);
      check("nh_wr_memwrite", 32'(ifb.MemWrite), 1);
      step(1'b0);
      check("nh_wr_done", 32'(ifb.State), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
